// File: rtl/debug_pkg.sv
// Shared definitions for the serial debug link: command characters, FSM
// encodings and ASCII hex conversion helpers.
package debug_pkg;

   localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
   localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
   localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
   localparam logic [7:0] CMD_BP   = 8'h42;  // 'B'
   localparam logic [7:0] CMD_CLR  = 8'h58;  // 'X'
   localparam logic [7:0] CR       = 8'h0D;
   localparam logic [7:0] LF       = 8'h0A;
   localparam logic [7:0] SPACE    = 8'h20;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_ADDR,
      P_TERM
   } parse_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] nibble;
   } hex_nibble_t;

   // Accepts 0-9, A-F and a-f; anything else returns valid=0.
   function automatic hex_nibble_t hex_to_nibble(input logic [7:0] c);
      hex_nibble_t r;
      logic [7:0]  d;
      r = '0;
      d = '0;
      if (c >= 8'h30 && c <= 8'h39) begin
         d = c - 8'h30;
         r.valid = 1'b1;
      end else if (c >= 8'h41 && c <= 8'h46) begin
         d = c - 8'h37;
         r.valid = 1'b1;
      end else if (c >= 8'h61 && c <= 8'h66) begin
         d = c - 8'h57;
         r.valid = 1'b1;
      end
      r.nibble = d[3:0];
      return r;
   endfunction

   function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, one-clock
// byte_valid / frame_err pulses.
module uart_rx
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err
);

   localparam int             CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  C_HALF = CW'(CLKS_PER_BIT / 2);

   rx_state_t     r_state;
   logic          r_rx_meta;
   logic          r_rx_sync;
   logic          r_seen_high;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_byte_valid;
   logic          r_frame_err;

   // NOTE: every register here is assigned with <= so all of them update
   // together from the values present before the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta    <= 1'b0;
         r_rx_sync    <= 1'b0;
         r_seen_high  <= 1'b0;
         r_state      <= R_IDLE;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_rx_meta    <= i_rx;
         r_rx_sync    <= r_rx_meta;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         // A line still held low out of reset must not look like a start bit.
         if (r_rx_sync) r_seen_high <= 1'b1;

         case (r_state)
            R_IDLE: begin
               if (r_seen_high && !r_rx_sync) begin
                  r_state <= R_START;
                  r_cnt   <= '0;
               end
            end
            R_START: begin
               if (r_cnt == C_HALF) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= r_rx_sync ? R_IDLE : R_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            R_DATA: begin
               if (r_cnt == C_LAST) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rx_sync, r_shift[7:1]};
                  if (r_bit == 3'd7) r_state <= R_STOP;
                  else               r_bit   <= r_bit + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            R_STOP: begin
               if (r_cnt == C_LAST) begin
                  r_cnt   <= '0;
                  r_state <= R_IDLE;
                  if (r_rx_sync) r_byte_valid <= 1'b1;
                  else           r_frame_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign o_byte       = r_shift;
   assign o_byte_valid = r_byte_valid;
   assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/debug_cmd_rx.sv
// Debug link command receiver: decodes H/C/S/X/Bhhhh commands from the UART
// and drives halt/step plus a single address breakpoint.
module debug_cmd_rx
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx,
   input  logic [15:0] addr,
   output logic        halt,
   output logic        step,
   output logic [15:0] bp_addr,
   output logic        bp_valid,
   output logic        cmd_err
);

   logic [7:0]   w_byte;
   logic         w_byte_valid;
   logic         w_frame_err;
   hex_nibble_t  w_hex;
   logic         w_is_eol;
   logic         w_hit;

   parse_state_t r_pstate;
   logic [1:0]   r_nib_cnt;
   logic [15:0]  r_shadow;
   logic         r_halt;
   logic         r_step;
   logic [15:0]  r_bp_addr;
   logic         r_bp_valid;
   logic         r_cmd_err;
   logic         r_match;
   logic         r_match_d;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_rx         (rx),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (w_frame_err)
   );

   assign w_hex    = hex_to_nibble(w_byte);
   assign w_is_eol = (w_byte == CR) || (w_byte == LF);
   // Only the rising edge halts, so 'C' while parked on the breakpoint sticks.
   assign w_hit    = r_match && !r_match_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pstate   <= P_IDLE;
         r_nib_cnt  <= '0;
         r_shadow   <= '0;
         r_halt     <= 1'b0;
         r_step     <= 1'b0;
         r_bp_addr  <= '0;
         r_bp_valid <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_match    <= 1'b0;
         r_match_d  <= 1'b0;
      end else begin
         r_step    <= 1'b0;
         r_cmd_err <= 1'b0;
         r_match   <= r_bp_valid && (addr == r_bp_addr);
         r_match_d <= r_match;

         if (w_frame_err) begin
            r_cmd_err <= 1'b1;
            r_pstate  <= P_IDLE;
         end else if (w_byte_valid) begin
            case (r_pstate)
               P_IDLE: begin
                  case (w_byte)
                     CMD_HALT: r_halt     <= 1'b1;
                     CMD_CONT: r_halt     <= 1'b0;
                     CMD_STEP: r_step     <= r_halt;
                     CMD_CLR:  r_bp_valid <= 1'b0;
                     CMD_BP: begin
                        r_pstate  <= P_ADDR;
                        r_nib_cnt <= '0;
                     end
                     CR, LF, SPACE: begin
                     end
                     default:  r_cmd_err  <= 1'b1;
                  endcase
               end
               P_ADDR: begin
                  if (w_hex.valid) begin
                     r_shadow  <= {r_shadow[11:0], w_hex.nibble};
                     r_nib_cnt <= r_nib_cnt + 1'b1;
                     if (r_nib_cnt == 2'd3) r_pstate <= P_TERM;
                  end else begin
                     r_cmd_err <= 1'b1;
                     r_pstate  <= P_IDLE;
                  end
               end
               P_TERM: begin
                  if (w_is_eol) begin
                     r_bp_addr  <= r_shadow;
                     r_bp_valid <= 1'b1;
                  end else begin
                     r_cmd_err  <= 1'b1;
                  end
                  r_pstate <= P_IDLE;
               end
               default: r_pstate <= P_IDLE;
            endcase
         end

         // Placed last so a breakpoint hit overrides a 'C' in the same cycle.
         if (w_hit) r_halt <= 1'b1;
      end
   end

   assign halt     = r_halt;
   assign step     = r_step;
   assign bp_addr  = r_bp_addr;
   assign bp_valid = r_bp_valid;
   assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_debug_cmd_rx.sv
// Directed bench for debug_cmd_rx at 16 clocks per bit; outputs are sampled
// on the falling edge, stimulus changes 1 time unit after it.
module tb_debug_cmd_rx;

   localparam int BIT = 16;

   logic        clk;
   logic        reset_n;
   logic        rx;
   logic [15:0] addr;
   logic        halt;
   logic        step;
   logic [15:0] bp_addr;
   logic        bp_valid;
   logic        cmd_err;

   int n_checks = 0;
   int n_errors = 0;

   int cyc           = 0;
   int step_cnt      = 0;
   int err_cnt       = 0;
   int halt_rise_cyc = 0;
   logic halt_prev   = 1'b0;
   int last_start;

   debug_cmd_rx #(
      .CLKS_PER_BIT (BIT)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx       (rx),
      .addr     (addr),
      .halt     (halt),
      .step     (step),
      .bp_addr  (bp_addr),
      .bp_valid (bp_valid),
      .cmd_err  (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc       <= cyc + 1;
      halt_prev <= halt;
      if (halt && !halt_prev) halt_rise_cyc <= cyc + 1;
      if (step)    step_cnt <= step_cnt + 1;
      if (cmd_err) err_cnt  <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Called 1 unit after a falling edge; returns at the same phase, so two
   // consecutive calls leave no idle time between stop and next start.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      last_start = cyc;
      rx = 1'b0;
      wait_clks(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(BIT);
      end
      rx = stop;
      wait_clks(BIT);
      rx = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   int s0;
   int e0;

   initial begin
      rx      = 1'b1;
      addr    = 16'h0000;
      reset_n = 1'b0;
      wait_clks(4);
      check("rst_halt",     {31'd0, halt},     32'd0);
      check("rst_step",     {31'd0, step},     32'd0);
      check("rst_bp_addr",  {16'd0, bp_addr},  32'd0);
      check("rst_bp_valid", {31'd0, bp_valid}, 32'd0);
      check("rst_cmd_err",  {31'd0, cmd_err},  32'd0);
      reset_n = 1'b1;
      wait_clks(5);

      // 1: halt / step / continue. Stop sample lands 156 clocks after the
      // start bit is driven; halt follows two edges after that.
      send_byte("H", 1'b1);
      check("t1_halt_latency", halt_rise_cyc - last_start, 32'd157);
      check("t1_halt", {31'd0, halt}, 32'd1);
      s0 = step_cnt;
      send_byte("S", 1'b1);
      wait_clks(2);
      check("t1_step_once", step_cnt - s0, 32'd1);
      check("t1_halt_after_step", {31'd0, halt}, 32'd1);
      send_byte("C", 1'b1);
      check("t1_cont", {31'd0, halt}, 32'd0);
      s0 = step_cnt;
      e0 = err_cnt;
      send_byte("S", 1'b1);
      wait_clks(2);
      check("t1_step_ignored", step_cnt - s0, 32'd0);
      check("t1_step_no_err", err_cnt - e0, 32'd0);

      // 2: breakpoint set and hit.
      send_str("B1a2F\r");
      check("t2_bp_addr",  {16'd0, bp_addr},  32'h1A2F);
      check("t2_bp_valid", {31'd0, bp_valid}, 32'd1);
      addr = 16'h0100;
      wait_clks(3);
      check("t2_no_hit", {31'd0, halt}, 32'd0);
      addr = 16'h1A2F;
      wait_clks(3);
      check("t2_hit", {31'd0, halt}, 32'd1);
      send_byte("C", 1'b1);
      check("t2_cont_on_bp", {31'd0, halt}, 32'd0);
      wait_clks(20);
      check("t2_no_rehalt", {31'd0, halt}, 32'd0);
      addr = 16'h1A30;
      wait_clks(3);
      addr = 16'h1A2F;
      wait_clks(3);
      check("t2_rehit", {31'd0, halt}, 32'd1);
      addr = 16'h0000;
      send_byte("C", 1'b1);
      check("t2_cleared", {31'd0, halt}, 32'd0);

      // 3: malformed address, trailing bytes parsed as commands.
      e0 = err_cnt;
      send_str("B12G");
      wait_clks(2);
      check("t3_err_at_G", err_cnt - e0, 32'd1);
      send_byte("4", 1'b1);
      wait_clks(2);
      check("t3_err_at_4", err_cnt - e0, 32'd2);
      send_byte(8'h0D, 1'b1);
      wait_clks(2);
      check("t3_cr_ignored", err_cnt - e0, 32'd2);
      check("t3_bp_addr",  {16'd0, bp_addr},  32'h1A2F);
      check("t3_bp_valid", {31'd0, bp_valid}, 32'd1);

      // 4: framing error, then a short glitch.
      e0 = err_cnt;
      send_byte("H", 1'b0);
      wait_clks(30);
      check("t4_frame_err", err_cnt - e0, 32'd1);
      check("t4_halt_unchanged", {31'd0, halt}, 32'd0);
      e0 = err_cnt;
      rx = 1'b0;
      wait_clks(4);
      rx = 1'b1;
      wait_clks(30);
      check("t4_glitch_no_err", err_cnt - e0, 32'd0);
      check("t4_glitch_halt", {31'd0, halt}, 32'd0);

      // 5: back-to-back bytes.
      e0 = err_cnt;
      send_str("HX");
      wait_clks(2);
      check("t5_halt",     {31'd0, halt},     32'd1);
      check("t5_bp_valid", {31'd0, bp_valid}, 32'd0);
      check("t5_no_err",   err_cnt - e0,      32'd0);

      // 6: reset in the middle of a byte.
      send_str("B00FF\r");
      check("t6_armed", {16'd0, bp_addr}, 32'h00FF);
      rx = 1'b0;
      wait_clks(BIT);
      rx = 1'b0;
      wait_clks(BIT);
      rx = 1'b0;
      wait_clks(BIT / 2);
      reset_n = 1'b0;
      #1;
      check("t6_rst_halt",     {31'd0, halt},     32'd0);
      check("t6_rst_bp_valid", {31'd0, bp_valid}, 32'd0);
      check("t6_rst_bp_addr",  {16'd0, bp_addr},  32'd0);
      rx = 1'b1;
      wait_clks(3);
      reset_n = 1'b1;
      wait_clks(5);
      e0 = err_cnt;
      send_byte("C", 1'b1);
      wait_clks(2);
      check("t6_c_no_err", err_cnt - e0, 32'd0);
      check("t6_c_halt",   {31'd0, halt}, 32'd0);
      send_byte("H", 1'b1);
      check("t6_h_halt",   {31'd0, halt}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
